// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO. Writes are registered into an
// array; the head word is read combinationally, so it is valid whenever empty is low.
module sync_fwft_fifo #(
    parameter int DWIDTH   = 8,
    parameter int AWIDTH   = 6,
    parameter int AF_LEVEL = 2**AWIDTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [AWIDTH:0]   level,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 2**AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_L = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] AF_L    = (AWIDTH+1)'(AF_LEVEL);
    localparam logic [AWIDTH:0] AE_L    = (AWIDTH+1)'(AE_LEVEL);

    logic [DWIDTH-1:0] mem [DEPTH];

    logic [AWIDTH-1:0] wr_ptr_reg;
    logic [AWIDTH-1:0] rd_ptr_reg;
    logic [AWIDTH:0]   level_reg;
    logic              overflow_reg;
    logic              underflow_reg;

    logic wr_acc;
    logic rd_acc;

    // A pop in the same cycle frees a slot, so a full FIFO can still take a write.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    assign empty        = (level_reg == '0);
    assign full         = (level_reg == DEPTH_L);
    assign almost_empty = (level_reg <= AE_L);
    assign almost_full  = (level_reg >= AF_L);
    assign level        = level_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;
    assign rd_data      = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (wr_acc && !clr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (clr) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_reg <= wr_ptr_reg + AWIDTH'(1);
            end
            if (rd_acc) begin
                rd_ptr_reg <= rd_ptr_reg + AWIDTH'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   level_reg <= level_reg + (AWIDTH+1)'(1);
                2'b01:   level_reg <= level_reg - (AWIDTH+1)'(1);
                default: level_reg <= level_reg;
            endcase
            if (wr_en && full && !rd_acc) begin
                overflow_reg <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_fwft_fifo.sv
// Bench for sync_fwft_fifo: a hand-computed vector table, directed corner
// sequences and a randomized run, all checked against a queue-based model.
module tb_sync_fwft_fifo;

    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
    localparam int AFL   = 60;
    localparam int AEL   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic          full;
    logic          almost_empty;
    logic          almost_full;
    logic [AW:0]   level;
    logic          overflow;
    logic          underflow;

    sync_fwft_fifo #(
        .DWIDTH  (DW),
        .AWIDTH  (AW),
        .AF_LEVEL(AFL),
        .AE_LEVEL(AEL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .level       (level),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the FIFO contents as a queue plus two sticky bits.
    logic [DW-1:0] model_q[$];
    bit            model_of;
    bit            model_uf;

    typedef struct {
        logic          clr;
        logic          wr;
        logic [DW-1:0] wd;
        logic          rd;
        int            exp_level;
        logic          exp_empty;
        logic          exp_dv;
        logic [DW-1:0] exp_data;
        logic          exp_of;
        logic          exp_uf;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit c, input bit w, input logic [DW-1:0] d, input bit r);
        bit pop_ok;
        bit push_ok;
        if (c) begin
            model_q.delete();
            model_of = 0;
            model_uf = 0;
        end else begin
            pop_ok  = r && (model_q.size() > 0);
            push_ok = w && ((model_q.size() < DEPTH) || pop_ok);
            if (r && model_q.size() == 0) model_uf = 1;
            if (w && model_q.size() == DEPTH && !pop_ok) model_of = 1;
            if (pop_ok) void'(model_q.pop_front());
            if (push_ok) model_q.push_back(d);
        end
    endtask

    task automatic check_model(input string tag);
        int n;
        n = model_q.size();
        check({tag, ".level"}, 32'(level), 32'(n));
        check({tag, ".empty"}, 32'(empty), 32'(n == 0));
        check({tag, ".full"}, 32'(full), 32'(n == DEPTH));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AEL));
        check({tag, ".almost_full"}, 32'(almost_full), 32'(n >= AFL));
        check({tag, ".overflow"}, 32'(overflow), 32'(model_of));
        check({tag, ".underflow"}, 32'(underflow), 32'(model_uf));
        if (n > 0) check({tag, ".rd_data"}, 32'(rd_data), 32'(model_q[0]));
    endtask

    // One clock cycle: drive inputs, take the edge, sample 1 ns later.
    task automatic cycle(input bit c, input bit w, input logic [DW-1:0] d, input bit r);
        clr     = c;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #1;
        model_step(c, w, d, r);
        clr   = 0;
        wr_en = 0;
        rd_en = 0;
        $display("t=%0t clr=%0b wr=%0b wd=%02h rd=%0b -> level=%0d rd_data=%02h of=%0b uf=%0b",
                 $time, c, w, d, r, level, rd_data, overflow, underflow);
    endtask

    initial begin
        // Test plan 1 and 4 as hand-computed vectors.
        tbl[0] = '{0, 1, 8'h11, 0, 1, 0, 1, 8'h11, 0, 0};
        tbl[1] = '{0, 1, 8'h22, 0, 2, 0, 1, 8'h11, 0, 0};
        tbl[2] = '{0, 1, 8'h33, 0, 3, 0, 1, 8'h11, 0, 0};
        tbl[3] = '{0, 0, 8'h00, 1, 2, 0, 1, 8'h22, 0, 0};
        tbl[4] = '{0, 0, 8'h00, 1, 1, 0, 1, 8'h33, 0, 0};
        tbl[5] = '{0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0};
        tbl[6] = '{0, 1, 8'h5C, 1, 1, 0, 1, 8'h5C, 0, 1};
        tbl[7] = '{0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 1};
        tbl[8] = '{1, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0};
        tbl[9] = '{0, 1, 8'hA7, 0, 1, 0, 1, 8'hA7, 0, 0};

        rst = 1; clr = 0; wr_en = 0; wr_data = '0; rd_en = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.level", 32'(level), 0);
        check("reset.empty", 32'(empty), 1);
        check("reset.full", 32'(full), 0);
        check("reset.almost_empty", 32'(almost_empty), 1);
        check("reset.almost_full", 32'(almost_full), 0);
        check("reset.overflow", 32'(overflow), 0);
        check("reset.underflow", 32'(underflow), 0);
        rst = 0;

        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].clr, tbl[i].wr, tbl[i].wd, tbl[i].rd);
            check($sformatf("vec%0d.level", i), 32'(level), 32'(tbl[i].exp_level));
            check($sformatf("vec%0d.empty", i), 32'(empty), 32'(tbl[i].exp_empty));
            check($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(tbl[i].exp_of));
            check($sformatf("vec%0d.underflow", i), 32'(underflow), 32'(tbl[i].exp_uf));
            if (tbl[i].exp_dv) check($sformatf("vec%0d.rd_data", i), 32'(rd_data), 32'(tbl[i].exp_data));
        end
        cycle(1, 0, 8'h00, 0);
        check_model("clr0");

        // Fill with 0..63; almost_full from level 60, full at 64.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 1, 8'(i), 0);
            check_model($sformatf("fill%0d", i));
        end
        check("fill.full", 32'(full), 1);
        check("fill.almost_full", 32'(almost_full), 1);

        // Full: simultaneous pop and push of 0xAA; head word 0 is consumed.
        check("swap.pre_rd_data", 32'(rd_data), 0);
        cycle(0, 1, 8'hAA, 1);
        check("swap.level", 32'(level), 64);
        check("swap.overflow", 32'(overflow), 0);
        check_model("swap");

        // Write without pop while full: dropped, overflow set.
        cycle(0, 1, 8'hEE, 0);
        check("ovf.overflow", 32'(overflow), 1);
        check("ovf.level", 32'(level), 64);
        check_model("ovf");

        // Drain: 1..63 then 0xAA, across the pointer wrap.
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("drain%0d.rd_data", i), 32'(rd_data), (i < 63) ? 32'(i + 1) : 32'hAA);
            cycle(0, 0, 8'h00, 1);
            check_model($sformatf("drain%0d", i));
        end
        check("drain.empty", 32'(empty), 1);

        // level=10 with overflow still set, then clr together with a write.
        for (int i = 0; i < 10; i++) cycle(0, 1, 8'(8'h80 + i), 0);
        check("pre_clr.level", 32'(level), 10);
        check("pre_clr.overflow", 32'(overflow), 1);
        cycle(1, 1, 8'h99, 0);
        check("clr.level", 32'(level), 0);
        check("clr.empty", 32'(empty), 1);
        check("clr.overflow", 32'(overflow), 0);
        check("clr.underflow", 32'(underflow), 0);
        check_model("clr");

        // Asynchronous reset between edges at level 7.
        for (int i = 0; i < 7; i++) cycle(0, 1, 8'(8'h40 + i), 0);
        check("prerst.level", 32'(level), 7);
        #2;
        rst = 1;
        #1;
        check("arst.level", 32'(level), 0);
        check("arst.empty", 32'(empty), 1);
        check("arst.almost_empty", 32'(almost_empty), 1);
        @(posedge clk);
        #1;
        rst = 0;
        model_q.delete();
        model_of = 0;
        model_uf = 0;
        cycle(0, 1, 8'h3E, 0);
        check("rt.rd_data", 32'(rd_data), 32'h3E);
        cycle(0, 0, 8'h00, 1);
        check("rt.empty", 32'(empty), 1);
        check_model("rt");

        // Randomized traffic with phases biased toward full, empty and busy.
        for (int i = 0; i < 3000; i++) begin
            int wp;
            int rp;
            case ((i / 300) % 4)
                0:       begin wp = 90; rp = 20; end
                1:       begin wp = 20; rp = 90; end
                2:       begin wp = 60; rp = 60; end
                default: begin wp = 95; rp = 95; end
            endcase
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 99) < wp,
                  8'($urandom),
                  $urandom_range(0, 99) < rp);
            check_model($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fwft_fifo.md
Name: sync_fwft_fifo

Overview:
- Single-clock, first-word-fall-through FIFO built on an internal register-array memory: synchronous write, combinational (asynchronous) read.
- Provides pointer management, occupancy level, full/empty and programmable almost-flags, synchronous flush, and sticky overflow/underflow error flags.
- Serves as the generic buffering block between emulator bus-side producers and video/audio/peripheral consumers that share one clock domain.

Parameters:
DWIDTH, 8, data word width in bits
AWIDTH, 6, address width; depth DEPTH = 2**AWIDTH words
AF_LEVEL, 2**AWIDTH-4, almost_full asserted when level >= AF_LEVEL (legal range 1..DEPTH)
AE_LEVEL, 4, almost_empty asserted when level <= AE_LEVEL (legal range 0..DEPTH-1)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
clr  in  1  synchronous flush; empties the FIFO and clears the error flags
wr_en  in  1  write request
wr_data  in  DWIDTH  write data
rd_en  in  1  read/pop request; acknowledges the current rd_data
rd_data  out  DWIDTH  head word, combinational from memory[rd_ptr]
empty  out  1  level == 0
full  out  1  level == DEPTH
almost_empty  out  1  level <= AE_LEVEL
almost_full  out  1  level >= AF_LEVEL
level  out  AWIDTH+1  current occupancy, 0..DEPTH
overflow  out  1  sticky; write attempted while full without a simultaneous pop
underflow  out  1  sticky; rd_en asserted while empty

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset (rst=1, asynchronous):
  - wr_ptr, rd_ptr and level are set to 0; overflow and underflow are set to 0.
  - Resulting outputs: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0), which is 0 for legal parameters.
  - Memory contents are not reset, so rd_data is undefined while empty.
- Pointers: AWIDTH bits wide and wrap naturally from DEPTH-1 to 0. level is a separate (AWIDTH+1)-bit counter. Flags are decoded combinationally from level and are registered-equivalent, with no extra latency.
- Write accept: wr_acc = wr_en & (~full | rd_acc).
  - On accept: memory[wr_ptr] <= wr_data and wr_ptr increments.
- Read accept: rd_acc = rd_en & ~empty.
  - On accept: rd_ptr increments.
  - rd_data is valid whenever empty=0, with zero latency (FWFT). The consumer samples it in the same cycle it asserts rd_en.
- Level update: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
- Simultaneous rd_en and wr_en:
  - Empty: the write is accepted and the read is rejected; underflow is set. The new word appears on rd_data in the next cycle (no same-cycle bypass).
  - Full: both are accepted and level stays at DEPTH. The write lands in the slot being vacated, whose old word was presented on rd_data before the edge.
  - Otherwise: both are accepted and level is unchanged.
- Error flags:
  - overflow <= 1 when wr_en & full & ~rd_acc. The write is dropped and state is unchanged.
  - underflow <= 1 when rd_en & empty.
  - Both flags hold until clr or rst.
- clr (synchronous): takes priority over wr_en and rd_en in the same cycle.
  - Pointers, level and both error flags go to 0.
  - Any write presented in that cycle is discarded.
- Reset mid-operation: all pointers, level and flags drop immediately, without waiting for a clock edge. Memory retains stale data, which is unreachable until rewritten.
- Width rules: level compares against AF_LEVEL and AE_LEVEL are unsigned at AWIDTH+1 bits. DEPTH is representable because level has AWIDTH+1 bits.

Test Plan:
1. Reset, then write 0x11,0x22,0x33 on consecutive cycles -> rd_data=0x11 the cycle after the first write; level=3; empty=0. Pop 3 times -> rd_data 0x11,0x22,0x33 in order; empty=1; level=0.
2. Fill with DEPTH=64 words 0..63 -> full=1 and almost_full=1 from level 60 upward. A 65th write without a pop -> overflow=1, level=64, contents unchanged. Drain -> values 0..63 read in order, confirming pointer wrap.
3. Full, then rd_en=wr_en=1 with wr_data=0xAA for one cycle -> rd_data=0 is consumed, level stays 64, overflow stays 0. After draining, the last word read is 0xAA.
4. Empty, then rd_en=wr_en=1 with wr_data=0x5C -> underflow=1, level=1, and rd_data=0x5C the next cycle.
5. level=10 with overflow set, then clr=1 together with wr_en=1 -> next cycle level=0, empty=1, overflow=0, underflow=0. Written word is absent.
6. Assert rst mid-stream at level=7, between clock edges -> level, empty and almost_empty become 0, 1 and 1 before the next edge. After release, a write/read of 0x3E round-trips correctly.
